seq_divider: RTL

- Iterative radix-2 restoring divider that performs the inverse of the adder path: repeated trial subtraction, one quotient bit per cycle.
- Implements RV32M DIV/DIVU/REM/REMU semantics for the execute stage.
- Sits beside the combinational ALU adder. It accepts one operation through a valid/ready handshake and holds the result until the consumer takes it.

---
 rtl/seq_divider.sv | 95 +++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider with RV32M DIV/DIVU/REM/REMU semantics.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve at accept.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_rem_sel, r_neg_q, r_neg_r;
  logic [WIDTH-1:0] r_div, r_rem, r_quo, r_result;
  logic             w_accept, w_retire, w_last, w_signed, w_a_neg, w_b_neg;
  logic             w_div0, w_ovf, w_special;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_special_res, w_rem_next, w_quo_next, w_final;
  logic [WIDTH:0]   w_shift, w_trial;

  assign w_accept      = in_valid & in_ready;
  assign w_retire      = out_valid & out_ready;
  assign w_last        = r_cnt == CW'(WIDTH-1);
  assign w_signed      = ~op[0];
  assign w_a_neg       = w_signed & dividend[WIDTH-1];
  assign w_b_neg       = w_signed & divisor[WIDTH-1];
  assign w_a_mag       = w_a_neg ? -dividend : dividend;
  assign w_b_mag       = w_b_neg ? -divisor : divisor;
  assign w_div0        = divisor == '0;
  assign w_ovf         = w_signed & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (&divisor);
  assign w_special     = w_div0 | w_ovf;
  assign w_special_res = w_div0 ? (op[1] ? dividend : '1) : (op[1] ? '0 : dividend);
  // The trial subtraction borrows into bit WIDTH when the divisor does not fit.
  assign w_shift       = {r_rem, r_quo[WIDTH-1]};
  assign w_trial       = w_shift - {1'b0, r_div};
  assign w_rem_next    = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_next    = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_final       = r_rem_sel ? (r_neg_r ? -w_rem_next : w_rem_next)
                                   : (r_neg_q ? -w_quo_next : w_quo_next);

  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? (w_special ? DONE : CALC) : IDLE;
      CALC:    w_next = w_last ? DONE : CALC;
      DONE:    w_next = w_retire ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
    busy      = r_state != IDLE;
    result    = r_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_result  <= '0;
      r_rem_sel <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_div     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
    end else if (w_accept) begin
      r_rem_sel <= op[1];
      r_neg_q   <= w_a_neg ^ w_b_neg;
      r_neg_r   <= w_a_neg;
      r_quo     <= w_a_mag;
      r_rem     <= '0;
      r_div     <= w_b_mag;
      r_cnt     <= '0;
      r_result  <= w_special ? w_special_res : r_result;
    end else if (r_state == CALC) begin
      r_rem    <= w_rem_next;
      r_quo    <= w_quo_next;
      r_cnt    <= r_cnt + CW'(1);
      r_result <= w_last ? w_final : r_result;
    end
  end
endmodule
